// File: rtl/drv_pwm.sv
`default_nettype none
// ============================================================================
// Module      : drv_pwm
// Description : Dead-time protected half-bridge PWM with a slew-limited duty
//               shadow register and a free-running 4096-cycle period.
// Revision    : 1.0 - initial release
// ============================================================================
module drv_pwm #(
    parameter int unsigned DEAD     = 32,
    parameter int unsigned MAX_STEP = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [11:0] drv_mag,
    output logic        pwm_hi,
    output logic        pwm_lo,
    output logic        period_start,
    output logic [11:0] duty
);

    localparam logic [12:0] C_DEAD     = 13'(DEAD);
    localparam logic [12:0] C_STEP     = 13'(MAX_STEP);
    localparam logic [11:0] C_CNT_LAST = 12'hFFF;

    logic [11:0] cnt_q,    cnt_d;
    logic [11:0] duty_q,   duty_d;
    logic        pwm_hi_q, pwm_hi_d;
    logic        pwm_lo_q, pwm_lo_d;
    logic        ps_q,     ps_d;

    logic        w_wrap;
    logic [12:0] w_cnt_ext;
    logic [12:0] w_duty_ext;
    logic [12:0] w_tgt_ext;
    logic [12:0] w_up;
    logic [12:0] w_dn_thr;
    logic [12:0] w_lo_thr;
    logic [11:0] w_ramp;

    always_comb begin
        w_wrap     = (cnt_q == C_CNT_LAST);
        w_cnt_ext  = {1'b0, cnt_q};
        w_duty_ext = {1'b0, duty_q};
        w_tgt_ext  = {1'b0, drv_mag};

        // 13-bit sums keep the slew comparisons free of wrap-around.
        w_up     = w_duty_ext + C_STEP;
        w_dn_thr = w_tgt_ext + C_STEP;
        w_lo_thr = w_duty_ext + C_DEAD;

        if (w_tgt_ext > w_up) begin
            w_ramp = w_up[11:0];
        end else if (w_dn_thr < w_duty_ext) begin
            w_ramp = duty_q - C_STEP[11:0];
        end else begin
            w_ramp = drv_mag;
        end

        cnt_d  = cnt_q + 12'd1;
        duty_d = duty_q;
        if (!en) begin
            duty_d = '0;
        end else if (w_wrap) begin
            duty_d = w_ramp;
        end

        pwm_hi_d = en && (w_cnt_ext >= C_DEAD) && (cnt_q < duty_q);
        pwm_lo_d = en && (w_cnt_ext >= w_lo_thr);
        ps_d     = w_wrap;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            duty_q   <= '0;
            pwm_hi_q <= 1'b0;
            pwm_lo_q <= 1'b0;
            ps_q     <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            duty_q   <= duty_d;
            pwm_hi_q <= pwm_hi_d;
            pwm_lo_q <= pwm_lo_d;
            ps_q     <= ps_d;
        end
    end

    assign pwm_hi       = pwm_hi_q;
    assign pwm_lo       = pwm_lo_q;
    assign period_start = ps_q;
    assign duty         = duty_q;

endmodule
`default_nettype wire

// File: tb/tb_drv_pwm.sv
`default_nettype none
// Bench for drv_pwm: per-cycle reference model, per-period vector table,
// hand-written boundary sequences and a randomized stretch.
module tb_drv_pwm;

    localparam int DEAD_T = 32;
    localparam int STEP_T = 1000;
    localparam int PER    = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [11:0] drv_mag;
    logic        pwm_hi;
    logic        pwm_lo;
    logic        period_start;
    logic [11:0] duty;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    int m_cnt  = 0;
    int m_duty = 0;
    bit m_hi   = 1'b0;
    bit m_lo   = 1'b0;
    bit m_ps   = 1'b0;

    typedef struct {
        logic [11:0] mag;
        int          duty_after;
        int          hi_cnt;
        int          lo_cnt;
    } vec_t;

    vec_t tbl [9];

    drv_pwm #(
        .DEAD     (DEAD_T),
        .MAX_STEP (STEP_T)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .drv_mag      (drv_mag),
        .pwm_hi       (pwm_hi),
        .pwm_lo       (pwm_lo),
        .period_start (period_start),
        .duty         (duty)
    );

    always #5 clk = ~clk;

    function automatic int ramp(input int cur, input int tgt);
        int d;
        d = tgt - cur;
        if (d > STEP_T)  d = STEP_T;
        if (d < -STEP_T) d = -STEP_T;
        return cur + d;
    endfunction

    // Reference: cnt is time since reset modulo the period; outputs lag cnt by one cycle.
    always @(posedge clk) begin
        if (rst) begin
            m_cnt  <= 0;
            m_duty <= 0;
            m_hi   <= 1'b0;
            m_lo   <= 1'b0;
            m_ps   <= 1'b0;
        end else begin
            m_hi <= (en == 1'b1) && (m_cnt >= DEAD_T) && (m_cnt < m_duty);
            m_lo <= (en == 1'b1) && (m_cnt >= m_duty + DEAD_T);
            m_ps <= (m_cnt == PER - 1);
            if (en != 1'b1)
                m_duty <= 0;
            else if (m_cnt == PER - 1)
                m_duty <= ramp(m_duty, int'(drv_mag));
            m_cnt <= (m_cnt + 1) % PER;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("cycle {ps,hi,lo,duty}", {17'd0, period_start, pwm_hi, pwm_lo, duty},
                  {17'd0, m_ps, m_hi, m_lo, m_duty[11:0]});
            check("no_overlap", {31'd0, pwm_hi & pwm_lo}, 32'd0);
        end
    end

    task automatic wait_cnt(input int k);
        int n;
        n = 0;
        while (m_cnt != k && n < 2 * PER) begin
            @(negedge clk);
            n++;
        end
        if (m_cnt != k) begin
            total++;
            bad++;
            $display("FAIL wait_cnt: cnt %0d never reached, stuck at %0d", k, m_cnt);
        end
    endtask

    initial begin
        int n;
        int hc;
        int lc;

        tbl[0] = '{12'd2048, 1000,    0, 4064};
        tbl[1] = '{12'd2048, 2000,  968, 3064};
        tbl[2] = '{12'd2048, 2048, 1968, 2064};
        tbl[3] = '{12'd4095, 3048, 2016, 2016};
        tbl[4] = '{12'd4095, 4048, 3016, 1016};
        tbl[5] = '{12'd4095, 4095, 4016,   16};
        tbl[6] = '{12'd1500, 3095, 4063,    0};
        tbl[7] = '{12'd1500, 2095, 3063,  969};
        tbl[8] = '{12'd1500, 1500, 2063, 1969};

        rst     = 1'b1;
        en      = 1'b1;
        drv_mag = tbl[0].mag;
        repeat (3) @(negedge clk);
        chk_on = 1'b1;
        check("reset pwm_hi", {31'd0, pwm_hi}, 32'd0);
        check("reset pwm_lo", {31'd0, pwm_lo}, 32'd0);
        check("reset period_start", {31'd0, period_start}, 32'd0);
        check("reset duty", {20'd0, duty}, 32'd0);
        rst = 1'b0;

        // One period per entry: hi/lo counts reflect the duty applied at its start.
        for (int i = 0; i < 9; i++) begin
            drv_mag = tbl[i].mag;
            hc = 0;
            lc = 0;
            repeat (PER) begin
                @(negedge clk);
                hc += int'(pwm_hi);
                lc += int'(pwm_lo);
            end
            check($sformatf("tbl[%0d] duty", i), duty, tbl[i].duty_after);
            check($sformatf("tbl[%0d] hi_cnt", i), hc, tbl[i].hi_cnt);
            check($sformatf("tbl[%0d] lo_cnt", i), lc, tbl[i].lo_cnt);
            check($sformatf("tbl[%0d] period_start", i), {31'd0, period_start}, 32'd1);
        end

        // Mid-period request change must wait for the boundary.
        drv_mag = 12'd1500;
        wait_cnt(1000);
        drv_mag = 12'd1480;
        wait_cnt(PER - 1);
        check("midperiod duty held", {20'd0, duty}, 32'd1500);
        @(negedge clk);
        check("midperiod duty applied", {20'd0, duty}, 32'd1480);

        // Enable drop mid-period, then soft start.
        wait_cnt(2000);
        en = 1'b0;
        @(negedge clk);
        check("en_off pwm_hi", {31'd0, pwm_hi}, 32'd0);
        check("en_off pwm_lo", {31'd0, pwm_lo}, 32'd0);
        check("en_off duty", {20'd0, duty}, 32'd0);
        repeat (5) @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        check("en_on pwm_lo resumes", {31'd0, pwm_lo}, 32'd1);
        wait_cnt(0);
        check("soft start duty", {20'd0, duty}, 32'd1000);

        // Enable drop coinciding with the wrap beats the ramp update.
        wait_cnt(PER - 1);
        en = 1'b0;
        @(negedge clk);
        check("en_off at wrap duty", {20'd0, duty}, 32'd0);
        check("en_off at wrap pwm_hi", {31'd0, pwm_hi}, 32'd0);
        en = 1'b1;
        @(negedge clk);
        wait_cnt(0);
        check("soft start after wrap drop", {20'd0, duty}, 32'd1000);

        // Randomized stretch against the reference model.
        repeat (2 * PER) begin
            int r;
            @(negedge clk);
            r = int'($urandom_range(0, 999));
            if (r < 2)
                drv_mag = 12'($urandom_range(0, 4095));
            else if (r < 4)
                drv_mag = 12'($urandom_range(0, 40));
            if (r == 5)
                en = ~en;
            rst = ($urandom_range(0, 4999) == 0);
        end
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b1;
        drv_mag = 12'd2048;

        // Reset pulse mid-period restarts the period.
        @(negedge clk);
        wait_cnt(1234);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid pwm_hi", {31'd0, pwm_hi}, 32'd0);
        check("rst_mid pwm_lo", {31'd0, pwm_lo}, 32'd0);
        check("rst_mid period_start", {31'd0, period_start}, 32'd0);
        check("rst_mid duty", {20'd0, duty}, 32'd0);
        rst = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (period_start !== 1'b1 && n < PER + 16);
        check("period_start after rst", n, PER);

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/drv_pwm.md
DRV_PWM -- requirements
Module: drv_pwm

Interface
REQ-001 Parameter DEAD, default 32, dead-time in clk cycles inserted before either output turns on; legal range 0..255.
REQ-002 Parameter MAX_STEP, default 64, maximum change in applied duty per PWM period; legal range 1..4095.
REQ-003 clk  input  1  system clock; the only clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 en  input  1  drive enable; low forces motor drive off.
REQ-006 drv_mag  input  12  unsigned requested drive magnitude from the PID block; 0 = off, 4095 = max.
REQ-007 pwm_hi  output  1  high-side gate drive, registered.
REQ-008 pwm_lo  output  1  low-side gate drive, registered.
REQ-009 period_start  output  1  one-cycle pulse, high in the cycle where cnt equals 0.
REQ-010 duty  output  12  currently applied duty value (shadow register contents).

Function
REQ-011 Internal 12-bit period counter cnt SHALL increment by 1 every cycle, wrapping from 4095 to 0; period is 4096 cycles; it runs regardless of en.
REQ-012 period_start SHALL be registered and high for exactly one cycle per period, in the cycle after cnt = 4095.
REQ-013 duty SHALL update only in the cycle where cnt = 4095 (new value effective from cnt = 0); drv_mag changes mid-period SHALL NOT affect the current period.
REQ-014 Duty update, computed at 13-bit width with no wrap: target = drv_mag; if target > duty + MAX_STEP, duty <- duty + MAX_STEP; else if target + MAX_STEP < duty, duty <- duty - MAX_STEP; else duty <- target.
REQ-015 Ramp result SHALL never exceed 4095 or go below 0.
REQ-016 pwm_hi next-cycle value SHALL be 1 iff en = 1 and DEAD <= cnt < duty (unsigned compare).
REQ-017 pwm_lo next-cycle value SHALL be 1 iff en = 1 and cnt >= duty + DEAD, with the sum at 13-bit width, so pwm_lo never asserts when duty + DEAD > 4095.
REQ-018 pwm_hi and pwm_lo SHALL never be 1 in the same cycle; each output's on-edge SHALL be preceded by at least DEAD cycles with both outputs low.
REQ-019 Latency from cnt to pwm_hi/pwm_lo SHALL be exactly 1 cycle.
REQ-020 duty = 0 SHALL yield pwm_hi always 0 and pwm_lo high for cnt in [DEAD, 4095]; duty <= DEAD SHALL yield pwm_hi always 0.
REQ-021 en = 0 SHALL force pwm_hi = pwm_lo = 0 on the next cycle and clear duty to 0 on the next cycle, regardless of cnt.
REQ-022 After en returns to 1, duty SHALL ramp from 0 per REQ-014 (soft start); outputs resume on the next cycle per REQ-016/017.
REQ-023 If en falls in the same cycle as cnt = 4095, the clear of REQ-021 SHALL take priority over the ramp update.

Reset
REQ-024 While rst = 1: cnt = 0, duty = 0, pwm_hi = 0, pwm_lo = 0, period_start = 0, all effective on the next clk edge.
REQ-025 Reset SHALL take priority over en and over any ramp update; reset asserted mid-period SHALL restart the period at cnt = 0 on the first cycle after rst deasserts.

Verification
REQ-026 Reset release, en = 1, drv_mag = 2048 -> duty steps 0, 64, 128, ... one step per period_start; reaches 2048 after 32 periods, then holds at 2048.
REQ-027 Steady state with duty = 2048, DEAD = 32 -> per period pwm_hi high for 2016 cycles (cnt 32..2047), pwm_lo high for 2016 cycles (cnt 2080..4095), never both high.
REQ-028 drv_mag changed from 2048 to 2000 at cnt = 1000 -> duty stays 2048 until the cycle after cnt = 4095, then reads 2000.
REQ-029 en dropped to 0 with duty = 3000 -> next cycle both outputs 0 and duty = 0; en restored -> duty 64 after the next period boundary.
REQ-030 drv_mag = 4095 for 64+ periods -> duty saturates at 4095; pwm_lo never asserts; pwm_hi high for cnt 32..4094.
REQ-031 rst pulsed at cnt = 1234 -> all outputs 0 and cnt = 0 on the next cycle; period_start first pulses 4096 cycles after rst deasserts.
